// File: rtl/l1_biu.sv
// l1_biu: memory-side bus interface unit of the unified L1 cache.
// Runs write-through, single-read and line-fill requests as byte bus cycles.
module l1_biu #(
    parameter int ADDR_WIDTH = 24,
    parameter int LINE_SIZE  = 128,
    parameter int LINE_WID   = $clog2(LINE_SIZE),
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_through_req,
    input  logic                  read_req,
    input  logic                  read_line_req,
    input  logic [ADDR_WIDTH-1:0] pa,
    input  logic [7:0]            wt_data,
    output logic [7:0]            line_data,
    output logic [LINE_WID-1:0]   addr_count,
    output logic                  line_write,
    output logic                  cache_entry_refill,
    output logic                  trans_rdy,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    input  logic                  mem_err
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BW = ADDR_WIDTH - LINE_WID;

    typedef enum logic [2:0] {
        IDLE, LREQ, LWR, SRD, SWR, DONE, FAULT
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         base_q, base_d;
    logic [LINE_WID-1:0]   beat_q, beat_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            line_data_q, line_data_d;
    logic [LINE_WID-1:0]   addr_count_q, addr_count_d;
    logic                  line_write_q, line_write_d;
    logic                  refill_q, refill_d;
    logic                  trans_rdy_q, trans_rdy_d;
    logic                  bus_error_q, bus_error_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  tmo_hit;
    logic                  bus_fail;

    // Timeout behaves exactly like mem_err, so it also wins over mem_ack.
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT));
    assign bus_fail = mem_err || tmo_hit;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        beat_d       = beat_q;
        tmo_d        = tmo_q;
        line_data_d  = line_data_q;
        addr_count_d = addr_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        line_write_d = 1'b0;
        refill_d     = 1'b0;
        trans_rdy_d  = 1'b0;
        bus_error_d  = 1'b0;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (read_line_req) begin
                    base_d      = pa[ADDR_WIDTH-1:LINE_WID];
                    beat_d      = '0;
                    mem_addr_d  = {pa[ADDR_WIDTH-1:LINE_WID], {LINE_WID{1'b0}}};
                    mem_wdata_d = wt_data;
                    mem_rd_d    = 1'b1;
                    state_d     = LREQ;
                end else if (read_req) begin
                    mem_addr_d  = pa;
                    mem_wdata_d = wt_data;
                    mem_rd_d    = 1'b1;
                    state_d     = SRD;
                end else if (write_through_req) begin
                    mem_addr_d  = pa;
                    mem_wdata_d = wt_data;
                    mem_wr_d    = 1'b1;
                    state_d     = SWR;
                end
            end
            LREQ: begin
                if (bus_fail) begin
                    bus_error_d = 1'b1;
                    state_d     = FAULT;
                end else if (mem_ack) begin
                    line_data_d  = mem_rdata;
                    addr_count_d = beat_q;
                    line_write_d = 1'b1;
                    state_d      = LWR;
                end else begin
                    mem_rd_d = 1'b1;
                    tmo_d    = tmo_q + TW'(1);
                end
            end
            LWR: begin
                if (beat_q == LINE_WID'(LINE_SIZE - 1)) begin
                    trans_rdy_d = 1'b1;
                    refill_d    = 1'b1;
                    state_d     = DONE;
                end else begin
                    beat_d     = beat_q + LINE_WID'(1);
                    mem_addr_d = {base_q, beat_q + LINE_WID'(1)};
                    mem_rd_d   = 1'b1;
                    tmo_d      = '0;
                    state_d    = LREQ;
                end
            end
            SRD: begin
                if (bus_fail) begin
                    bus_error_d = 1'b1;
                    state_d     = FAULT;
                end else if (mem_ack) begin
                    line_data_d = mem_rdata;
                    trans_rdy_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    mem_rd_d = 1'b1;
                    tmo_d    = tmo_q + TW'(1);
                end
            end
            SWR: begin
                if (bus_fail) begin
                    bus_error_d = 1'b1;
                    state_d     = FAULT;
                end else if (mem_ack) begin
                    trans_rdy_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    mem_wr_d = 1'b1;
                    tmo_d    = tmo_q + TW'(1);
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            beat_q       <= '0;
            tmo_q        <= '0;
            line_data_q  <= '0;
            addr_count_q <= '0;
            line_write_q <= 1'b0;
            refill_q     <= 1'b0;
            trans_rdy_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            line_data_q  <= line_data_d;
            addr_count_q <= addr_count_d;
            line_write_q <= line_write_d;
            refill_q     <= refill_d;
            trans_rdy_q  <= trans_rdy_d;
            bus_error_q  <= bus_error_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign line_data          = line_data_q;
    assign addr_count         = addr_count_q;
    assign line_write         = line_write_q;
    assign cache_entry_refill = refill_q;
    assign trans_rdy          = trans_rdy_q;
    assign bus_error          = bus_error_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_rd             = mem_rd_q;
    assign mem_wr             = mem_wr_q;
endmodule

// File: tb/tb_l1_biu.sv
// tb_l1_biu: scoreboard bench for l1_biu with a simple bus responder.
// Expected beats/completions are queued at stimulus time, popped on DUT output.
module tb_l1_biu;
    localparam int AW = 24;
    localparam int LS = 128;
    localparam int LW = 7;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_through_req, read_req, read_line_req;
    logic [AW-1:0] pa;
    logic [7:0]    wt_data;
    logic [7:0]    line_data;
    logic [LW-1:0] addr_count;
    logic          line_write, cache_entry_refill, trans_rdy, bus_error;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_rd, mem_wr;
    logic [7:0]    mem_rdata;
    logic          mem_ack, mem_err;

    always #5 clk = ~clk;

    l1_biu #(.ADDR_WIDTH(AW), .LINE_SIZE(LS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .write_through_req(write_through_req),
        .read_req(read_req), .read_line_req(read_line_req),
        .pa(pa), .wt_data(wt_data),
        .line_data(line_data), .addr_count(addr_count),
        .line_write(line_write),
        .cache_entry_refill(cache_entry_refill),
        .trans_rdy(trans_rdy), .bus_error(bus_error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    // kind: 8 = line_write beat, else {bus_error, refill, trans_rdy}
    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int data;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            cyc;
    int            wait_cfg, err_beat, beats, wcnt;
    int            rd_cyc, wr_cyc, first_stb;
    bit            noresp, done_seen, aborted;
    logic [7:0]    dmask, exp_wd;
    logic [AW-1:0] exp_base;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int n, input int d);
        exp_t e;
        e.kind = k; e.cyc = c; e.cnt = n; e.data = d;
        sb.push_back(e);
    endtask

    task automatic bus_drive();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        mem_rdata = 8'h00;
        if (mem_rd || mem_wr) begin
            if (first_stb < 0) first_stb = cyc;
            if (mem_rd) rd_cyc++;
            if (mem_wr) begin
                wr_cyc++;
                chk("wdata", 32'(mem_wdata), 32'(exp_wd));
            end
            if (!noresp) begin
                if (wcnt == wait_cfg) begin
                    chk("bus_addr", 32'(mem_addr), 32'(exp_base) + beats);
                    if (beats == err_beat) mem_err = 1'b1;
                    else begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_addr[7:0] ^ dmask;
                    end
                    wcnt = 0;
                    beats++;
                end else wcnt++;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        int code;
        chk("rdwr_excl", {31'b0, mem_rd & mem_wr}, 32'd0);
        if (line_write) begin
            if (sb.size() == 0) chk("lw_unexp", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("lw_kind", 32'd8, e.kind);
                chk("lw_cyc", cyc, e.cyc);
                chk("lw_cnt", 32'(addr_count), e.cnt);
                chk("lw_data", 32'(line_data), e.data);
            end
        end
        if (trans_rdy || bus_error || cache_entry_refill) begin
            done_seen = 1'b1;
            code = {29'b0, bus_error, cache_entry_refill, trans_rdy};
            if (sb.size() == 0) chk("end_unexp", code, 32'd0);
            else begin
                e = sb.pop_front();
                chk("end_kind", code, e.kind);
                chk("end_cyc", cyc, e.cyc);
                if (e.data >= 0) chk("end_data", 32'(line_data), e.data);
            end
        end
    endtask

    task automatic step();
        bus_drive();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic run(input int kind, input logic [AW-1:0] a,
                       input logic [7:0] wd, input int w, input int eb,
                       input bit nr, input logic [7:0] dm, input int abort_at);
        wait_cfg = w; err_beat = eb; noresp = nr; dmask = dm;
        beats = 0; wcnt = 0; rd_cyc = 0; wr_cyc = 0; first_stb = -1;
        done_seen = 1'b0; aborted = 1'b0; exp_wd = wd;
        exp_base = (kind & 1) != 0 ? {a[AW-1:LW], {LW{1'b0}}} : a;
        pa = a;
        wt_data = wd;
        read_line_req = (kind & 1) != 0;
        read_req = (kind & 2) != 0;
        write_through_req = (kind & 4) != 0;
        cyc = 0;
        while (!done_seen && !aborted && cyc < 600) begin
            if (cyc == abort_at) rst = 1'b1;
            step();
            if (rst) begin
                rst = 1'b0;
                aborted = 1'b1;
                chk("abort_rd", {31'b0, mem_rd}, 32'd0);
                chk("abort_lw", {31'b0, line_write}, 32'd0);
                chk("abort_addr", 32'(mem_addr), 32'd0);
            end
            if (done_seen) begin
                read_line_req = 1'b0;
                read_req = 1'b0;
                write_through_req = 1'b0;
            end
        end
        if (!done_seen && !aborted) chk("budget", 32'd0, 32'd1);
        read_line_req = 1'b0;
        read_req = 1'b0;
        write_through_req = 1'b0;
        repeat (3) step();
        chk("sb_empty", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        write_through_req = 1'b0;
        read_req = 1'b0;
        read_line_req = 1'b0;
        pa = '0;
        wt_data = '0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(line_data), 32'd0);
        chk("rst_cnt", 32'(addr_count), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_strobes", {26'b0, line_write, cache_entry_refill, trans_rdy,
                            bus_error, mem_rd, mem_wr}, 32'd0);
        rst = 1'b0;

        push(1, 2, 0, -1);
        run(4, 24'h001234, 8'hA5, 0, -1, 1'b0, 8'h00, -1);
        chk("wr_first", first_stb, 32'd1);
        chk("wr_cycles", wr_cyc, 32'd1);
        chk("wr_nord", rd_cyc, 32'd0);

        push(1, 5, 0, 8'h3C);
        run(2, 24'h0000FF, 8'h00, 3, -1, 1'b0, 8'hC3, -1);
        chk("rd_first", first_stb, 32'd1);
        chk("rd_cycles", rd_cyc, 32'd4);

        for (int k = 0; k < LS; k++) push(8, 2 + 2 * k, k, k);
        push(3, 257, 0, 8'h7F);
        run(1, 24'h012345, 8'h00, 0, -1, 1'b0, 8'h00, -1);
        chk("fill_rds", rd_cyc, 32'd128);

        for (int k = 0; k < 5; k++) push(8, 2 + 2 * k, k, 8'h80 + k);
        push(4, 12, 0, -1);
        run(1, 24'h004480, 8'h00, 0, 5, 1'b0, 8'h00, -1);

        push(4, 6, 0, -1);
        run(2, 24'h000777, 8'h00, 0, -1, 1'b1, 8'h00, -1);
        chk("tmo_rds", rd_cyc, 32'd5);

        for (int k = 0; k < LS; k++) push(8, 2 + 2 * k, k, 8'h80 + k);
        push(3, 257, 0, 8'hFF);
        run(5, 24'h00AB80, 8'h11, 0, -1, 1'b0, 8'h00, -1);
        chk("pri_nowr", wr_cyc, 32'd0);

        for (int k = 0; k < 10; k++) push(8, 2 + 2 * k, k, k);
        run(1, 24'h003300, 8'h00, 0, -1, 1'b0, 8'h00, 21);
        chk("abort_rds", rd_cyc, 32'd11);

        push(1, 2, 0, 8'h42);
        run(2, 24'h000042, 8'h00, 0, -1, 1'b0, 8'h00, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
